// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit external SRAM word-access controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int SRAM_AW       = 18;
    localparam int SRAM_DW       = 16;
    localparam int ADDR_BASE_DEF = 1024;

endpackage

// File: rtl/sram_controller.sv
// Turns one 32-bit MEM-stage load/store into two 16-bit accesses on an async SRAM,
// holding ready low while the access is in flight so the pipeline freezes.
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_BASE  = ADDR_BASE_DEF,
    parameter int ACCESS_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output state_t             state_dbg
);

    localparam int CW = $clog2(ACCESS_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYC - 1);

    // Handshake: rd_en/wr_en are levels held by the requester until it sees
    // ready=1; ready=1 in DONE completes the request, ready=1 in IDLE means no request.

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [16:0]        word_q, word_in, word_n;
    logic [31:0]        wdata_q, wdata_n, offset;
    logic               last, we_strobe;
    logic [SRAM_AW-1:0] addr_n;
    logic [SRAM_DW-1:0] dq_out_n;
    logic               dq_oe_n, we_n_n, oe_n_n;
    logic               unused_offset_bits;

    assign offset             = addr - 32'(ADDR_BASE);
    assign word_in            = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign last               = (cnt == CNT_LAST);
    assign ready              = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);
    assign state_dbg          = state;
    assign sram_ce_n          = 1'b0;
    assign sram_ub_n          = 1'b0;
    assign sram_lb_n          = 1'b0;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            IDLE: begin
                if (wr_en)      state_n = WR_LO;
                else if (rd_en) state_n = RD_LO;
            end
            RD_LO: if (last) state_n = RD_HI; else cnt_n = cnt + CW'(1);
            RD_HI: if (last) state_n = DONE;  else cnt_n = cnt + CW'(1);
            WR_LO: if (last) state_n = WR_HI; else cnt_n = cnt + CW'(1);
            WR_HI: if (last) state_n = DONE;  else cnt_n = cnt + CW'(1);
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // SRAM pins are computed from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        word_n    = (state == IDLE) ? word_in : word_q;
        wdata_n   = (state == IDLE) ? wdata : wdata_q;
        we_strobe = (ACCESS_CYC == 1) || (cnt_n != CNT_LAST);
        addr_n    = sram_addr;
        dq_out_n  = sram_dq_out;
        dq_oe_n   = 1'b0;
        we_n_n    = 1'b1;
        oe_n_n    = 1'b1;
        case (state_n)
            RD_LO: begin
                addr_n = {word_n, 1'b0};
                oe_n_n = 1'b0;
            end
            RD_HI: begin
                addr_n = {word_n, 1'b1};
                oe_n_n = 1'b0;
            end
            WR_LO: begin
                addr_n   = {word_n, 1'b0};
                dq_out_n = wdata_n[15:0];
                dq_oe_n  = 1'b1;
                we_n_n   = ~we_strobe;
            end
            WR_HI: begin
                addr_n   = {word_n, 1'b1};
                dq_out_n = wdata_n[31:16];
                dq_oe_n  = 1'b1;
                we_n_n   = ~we_strobe;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            word_q      <= word_n;
            wdata_q     <= wdata_n;
            sram_addr   <= addr_n;
            sram_dq_out <= dq_out_n;
            sram_dq_oe  <= dq_oe_n;
            sram_we_n   <= we_n_n;
            sram_oe_n   <= oe_n_n;
            if (state == RD_LO && last) rdata[15:0]  <= sram_dq_in;
            if (state == RD_HI && last) rdata[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYC=2 and 1), each with a
// behavioural SRAM, checked against a word-level reference memory.
module tb_sram_controller;
    import sram_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          oe_lo;
        int          we_lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en, wr_en, ready, dq_oe, we_n, oe_n, ce_n, ub_n, lb_n;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [17:0] sram_addr [2];
    logic [15:0] dq_out [2];
    logic [15:0] dq_in [2];
    state_t      state_dbg [2];

    logic [15:0] mem [2][262144];
    logic        pre_en;
    int          pre_inst;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;

    logic [31:0] ref_word [2][64];
    logic [31:0] ref_rdata [2];
    exp_t        exp_q [2][$];
    logic        mon_off;
    int          lo_cnt [2];
    int          oe_cnt [2];
    int          we_cnt [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_controller #(.ADDR_BASE(1024), .ACCESS_CYC((g == 0) ? 2 : 1)) dut (
            .clk(clk), .rst(rst), .rd_en(rd_en[g]), .wr_en(wr_en[g]),
            .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]),
            .sram_addr(sram_addr[g]), .sram_dq_out(dq_out[g]), .sram_dq_oe(dq_oe[g]),
            .sram_dq_in(dq_in[g]), .sram_we_n(we_n[g]), .sram_oe_n(oe_n[g]),
            .sram_ce_n(ce_n[g]), .sram_ub_n(ub_n[g]), .sram_lb_n(lb_n[g]),
            .state_dbg(state_dbg[g])
        );

        // sram_model: async read while OE is low, write when WE is low and the bus is driven
        assign dq_in[g] = (!oe_n[g] && we_n[g] && !ce_n[g]) ? mem[g][sram_addr[g]] : 16'hBAD0;
        always @(posedge clk) begin
            if (pre_en && pre_inst == g) begin
                mem[g][pre_addr] <= pre_data;
            end else if (!ce_n[g] && !we_n[g] && dq_oe[g]) begin
                if (!lb_n[g]) mem[g][sram_addr[g]][7:0]  <= dq_out[g][7:0];
                if (!ub_n[g]) mem[g][sram_addr[g]][15:8] <= dq_out[g][15:8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: counts the stall cycles and SRAM strobes of each request and
    // scores them when the DUT presents ready with a request still raised.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || mon_off) begin
                lo_cnt[i] = 0; oe_cnt[i] = 0; we_cnt[i] = 0;
            end else if (rd_en[i] || wr_en[i]) begin
                if (!oe_n[i]) oe_cnt[i]++;
                if (!we_n[i]) we_cnt[i]++;
                if (!ready[i]) begin
                    lo_cnt[i]++;
                end else if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_done%0d", i), 32'(ready[i]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    chk($sformatf("rdata%0d", i), rdata[i], e.data);
                    chk($sformatf("stall_cycles%0d", i), 32'(lo_cnt[i]), 32'(e.lat));
                    chk($sformatf("oe_low_cycles%0d", i), 32'(oe_cnt[i]), 32'(e.oe_lo));
                    chk($sformatf("we_low_cycles%0d", i), 32'(we_cnt[i]), 32'(e.we_lo));
                    lo_cnt[i] = 0; oe_cnt[i] = 0; we_cnt[i] = 0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic do_req(input int i, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   ac, w;
        bit   done;
        ac = (i == 0) ? 2 : 1;
        w  = int'(((a - 32'd1024) >> 2) & 32'd63);
        if (wr) begin
            ref_word[i][w] = d;
            e.oe_lo = 0;
            e.we_lo = 2 * ((ac > 1) ? ac - 1 : 1);
        end else begin
            ref_rdata[i] = ref_word[i][w];
            e.oe_lo = 2 * ac;
            e.we_lo = 0;
        end
        e.data = ref_rdata[i];
        e.lat  = 1 + 2 * ac;
        exp_q[i].push_back(e);
        rd_en[i] = rd; wr_en[i] = wr; addr[i] = a; wdata[i] = d;
        done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready[i]) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            addr[i]  = $urandom;   // must be ignored once latched
            wdata[i] = $urandom;
        end
        if (!done) chk($sformatf("ready_timeout%0d", i), 32'(ready[i]), 32'd1);
        @(posedge clk); #1;
        rd_en[i] = 1'b0; wr_en[i] = 1'b0;
    endtask

    task automatic preload(input int i, input int half, input logic [15:0] d);
        pre_en = 1'b1; pre_inst = i; pre_addr = 18'(half); pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; rd_en = '0; wr_en = '0; pre_en = 1'b0; pre_inst = 0;
        pre_addr = '0; pre_data = '0; mon_off = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; ref_rdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 64; w++) begin
                d = $urandom;
                ref_word[i][w] = d;
                preload(i, 2 * w, d[15:0]);
                preload(i, 2 * w + 1, d[31:16]);
            end
        end

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd1);
            chk("reset_rdata", rdata[i], 32'd0);
            chk("reset_we_n", 32'(we_n[i]), 32'd1);
            chk("reset_oe_n", 32'(oe_n[i]), 32'd1);
            chk("reset_dq_oe", 32'(dq_oe[i]), 32'd0);
            chk("reset_sram_addr", 32'(sram_addr[i]), 32'd0);
            chk("reset_state", 32'(state_dbg[i]), 32'(IDLE));
        end
        @(posedge clk); #1;

        do_req(0, 0, 1, 32'd1024, 32'hDEADBEEF);
        chk("write_lo_half", 32'(mem[0][0]), 32'h0000BEEF);
        chk("write_hi_half", 32'(mem[0][1]), 32'h0000DEAD);
        preload(0, 4, 16'h5678);
        preload(0, 5, 16'h1234);
        ref_word[0][2] = 32'h12345678;
        do_req(0, 1, 0, 32'd1032, 32'd0);
        do_req(0, 0, 1, 32'd1028, 32'hA5A55A5A);
        do_req(0, 1, 0, 32'd1028, 32'd0);
        do_req(0, 1, 1, 32'd1040, 32'h0000FFFF);
        chk("both_en_lo_half", 32'(mem[0][8]), 32'h0000FFFF);
        chk("both_en_hi_half", 32'(mem[0][9]), 32'h00000000);
        do_req(1, 0, 1, 32'd1036, 32'hCAFEF00D);
        do_req(1, 1, 0, 32'd1036, 32'd0);

        for (int n = 0; n < 80; n++) begin
            int  i, kind;
            i    = $urandom_range(0, 1);
            kind = $urandom_range(0, 4);
            do_req(i, kind != 1, kind == 1 || kind == 4,
                   32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3)),
                   $urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        do_req(0, 1, 0, 32'd1024 + 32'd12, 32'd0);
        mon_off = 1'b1;
        d = $urandom;
        wr_en[0] = 1'b1; addr[0] = 32'd1064; wdata[0] = d;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_reset_in_wr_hi", 32'(state_dbg[0]), 32'(WR_HI));
        rst = 1'b1; wr_en[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_state", 32'(state_dbg[0]), 32'(IDLE));
        chk("mid_reset_we_n", 32'(we_n[0]), 32'd1);
        chk("mid_reset_dq_oe", 32'(dq_oe[0]), 32'd0);
        chk("mid_reset_ready", 32'(ready[0]), 32'd1);
        chk("mid_reset_rdata", rdata[0], 32'd0);
        // both halves had their WE pulse before the reset landed
        ref_word[0][10] = d;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        mon_off = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1, 0, 32'd1064, 32'd0);

        for (int i = 0; i < 2; i++) begin
            chk("scoreboard_drained", 32'(exp_q[i].size()), 32'd0);
            for (int w = 0; w < 64; w++)
                chk($sformatf("sram%0d_word%0d", i, w), {mem[i][2 * w + 1], mem[i][2 * w]},
                    ref_word[i][w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder for the data-memory requests issued by the MEM stage of the ARM pipeline. It converts one 32-bit word read or write into two 16-bit accesses on the external 256K×16 asynchronous SRAM. While an access is in flight it holds `ready` low; the top level freezes every pipeline register on `~ready`. It replaces the single-cycle data memory behind the MEM stage; the pipeline and forwarding logic are unchanged apart from the freeze term.

## Interface
Parameters:
- `ADDR_BASE`, default 1024: byte address of the first data word; subtracted from `addr` before indexing.
- `ACCESS_CYC`, default 2, legal range ≥1: number of cycles each 16-bit half-access holds address and controls stable.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rd_en`  in  1  MEM-stage read request; level, held until `ready`.
- `wr_en`  in  1  MEM-stage write request; level, held until `ready`.
- `addr`  in  32  byte address (ALU result); bits [1:0] are ignored.
- `wdata`  in  32  store data (val_rm).
- `rdata`  out  32  load data; valid in the cycle `ready` returns high after a read, held until the next read completes.
- `ready`  out  1  0 = stall the pipeline; 1 = the request is complete, or there is no request.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_oe`  out  1  1 = drive the DQ bus with `sram_dq_out`.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_we_n`  out  1  active-low write enable.
- `sram_oe_n`  out  1  active-low output enable.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied to 0.

## Operation
- Word index `w = (addr - ADDR_BASE) >> 2`, truncated to 17 bits. The low half is at `{w,1'b0}` and the high half at `{w,1'b1}`.
- States:
  - IDLE: `wr_en` → WR_LO; otherwise `rd_en` → RD_LO; otherwise stay in IDLE.
  - RD_LO and RD_HI: `sram_oe_n=0`, `sram_dq_oe=0`.
  - WR_LO and WR_HI: `sram_dq_oe=1`, `sram_dq_out` = the corresponding half of the latched `wdata`.
  - DONE: always → IDLE.
- Each LO/HI state lasts exactly ACCESS_CYC cycles, counted by `cnt`. `cnt` clears on every state entry.
- In write states, `sram_we_n=0` on every cycle of the phase except the last, which gives address and data hold time. With ACCESS_CYC=1, `sram_we_n=0` for that single cycle.
- Read halves are captured on the last cycle of RD_LO (into `rdata[15:0]`) and of RD_HI (into `rdata[31:16]`).
- `addr` and `wdata` are latched on the IDLE→LO transition. Later changes on the inputs are ignored.
- `ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`. This is combinational so the stall starts in the request's first cycle.
- `rd_en` and `wr_en` both high: the write is performed and the read is ignored. This is illegal for the pipeline, but the behaviour is deterministic.
- Requests arriving in DONE are not sampled. The request seen in the following IDLE cycle is treated as new; the pipeline has advanced by then.

## Timing
- Reset values:
  - state IDLE, `cnt` 0;
  - `rdata` 0;
  - `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0;
  - `sram_we_n` 1, `sram_oe_n` 1.
- `ready` is 1 after reset when there is no request.
- Latency: `ready` is low for 1 + 2·ACCESS_CYC cycles (IDLE detect plus the two halves) and high in DONE. With the default this is 5 cycles low, with ready high on cycle 6.
- Back-to-back requests: DONE → IDLE costs one `ready`-high idle cycle before the next request is detected. One word therefore occupies 2 + 2·ACCESS_CYC cycles.
- `rst` mid-access: the FSM returns to IDLE next edge, controls are deasserted, and a write may leave the word half-written. `rdata` resets to 0.
- `sram_addr`, `sram_we_n`, `sram_oe_n`, `sram_dq_*` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE);
  - `SRAM_AW=18`, `SRAM_DW=16`;
  - the `ADDR_BASE` default.
- Single module; the phase counter is inline, with width `$clog2(ACCESS_CYC+1)`.
- The top level adds `freeze = haz_freeze | ~ready` and holds all pipeline registers, including EXE/MEM and MEM/WB, on `~ready`.
- The bench uses a behavioural SRAM model, `sram_model`, with the same port names.

## Test plan
- Write `addr=1024`, `wdata=0xDEADBEEF` → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; `ready` low for exactly 5 cycles; `sram_we_n` low 1 cycle per half.
- Read `addr=1032` after the model is preloaded with SRAM[4]=0x5678, SRAM[5]=0x1234 → `rdata=0x12345678` in the DONE cycle; `sram_oe_n` low for 4 cycles.
- Back-to-back write 1028/0xA5A55A5A then read 1028 → read returns 0xA5A55A5A; the second request's `ready` drops one cycle after the first DONE.
- `rd_en=wr_en=1`, `addr=1040`, `wdata=0x0000FFFF` → SRAM[8]=0xFFFF, SRAM[9]=0x0000; `rdata` unchanged.
- Assert `rst` in the second cycle of WR_HI → next cycle IDLE, `sram_we_n=1`, `sram_dq_oe=0`, `ready=1`, `rdata=0`.
- ACCESS_CYC=1 build: any request → `ready` low 3 cycles; data correct for both read and write.
